// File: rtl/keypad.sv
// Decimal keypad front end: synchronizes and debounces a one-hot 10-key bus and
// shifts each accepted key, as a BCD digit, into a 4-digit entry register.
module keypad #(
  parameter int DEBOUNCE_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset_shift,
  input  logic [9:0]  keypad_buttons,
  output logic [15:0] keypad_values,
  output logic        shift_pulse
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] DC = CW'(DEBOUNCE_CYCLES);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_DEBOUNCE = 2'd1;
  localparam logic [1:0] S_HELD     = 2'd2;

  logic [9:0]    r_sync1;
  logic [9:0]    r_sync2;
  logic [1:0]    r_state;
  logic [3:0]    r_cand;
  logic [CW-1:0] r_cnt;
  logic [15:0]   r_values;
  logic          r_pulse;

  logic          w_zero;
  logic          w_valid;
  logic [3:0]    w_digit;
  logic [CW-1:0] w_cnt_inc;

  assign w_zero    = (r_sync2 == 10'h000);
  assign w_valid   = $onehot(r_sync2);
  assign w_cnt_inc = r_cnt + CW'(1);

  // One-hot to BCD; only meaningful when w_valid, so the encoder never sees multi-key input.
  always_comb begin
    w_digit = 4'd0;
    for (int i = 0; i < 10; i++) begin
      if (r_sync2[i]) w_digit = 4'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_shift) begin
      r_sync1  <= 10'h000;
      r_sync2  <= 10'h000;
      r_state  <= S_IDLE;
      r_cand   <= 4'd0;
      r_cnt    <= '0;
      r_values <= 16'h0000;
      r_pulse  <= 1'b0;
    end else begin
      r_sync1 <= keypad_buttons;
      r_sync2 <= r_sync1;
      r_pulse <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_valid) begin
            r_cand <= w_digit;
            // A single-sample debounce accepts on the very first valid sample.
            if (DEBOUNCE_CYCLES == 1) begin
              r_values <= {r_values[11:0], w_digit};
              r_pulse  <= 1'b1;
              r_cnt    <= '0;
              r_state  <= S_HELD;
            end else begin
              r_cnt   <= CW'(1);
              r_state <= S_DEBOUNCE;
            end
          end
        end
        S_DEBOUNCE: begin
          if (w_valid && (w_digit == r_cand)) begin
            if (w_cnt_inc == DC) begin
              r_values <= {r_values[11:0], r_cand};
              r_pulse  <= 1'b1;
              r_cnt    <= '0;
              r_state  <= S_HELD;
            end else begin
              r_cnt <= w_cnt_inc;
            end
          end else begin
            r_cnt   <= '0;
            r_state <= S_IDLE;
          end
        end
        S_HELD: begin
          // Counter is reused to measure consecutive all-released samples.
          if (w_zero) begin
            if (w_cnt_inc == DC) begin
              r_cnt   <= '0;
              r_state <= S_IDLE;
            end else begin
              r_cnt <= w_cnt_inc;
            end
          end else begin
            r_cnt <= '0;
          end
        end
        default: begin
          r_cnt   <= '0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign keypad_values = r_values;
  assign shift_pulse   = r_pulse;

endmodule

// File: tb/tb_keypad.sv
// Directed self-checking bench for keypad with hand-computed BCD entry values.
module tb_keypad;

  logic        clk;
  logic        reset_shift;
  logic [9:0]  keypad_buttons;
  logic [15:0] keypad_values;
  logic        shift_pulse;

  int n_cmp;
  int n_err;
  int pulses;
  int first_at;
  int step_no;

  keypad #(.DEBOUNCE_CYCLES(2)) dut (
    .clk            (clk),
    .reset_shift    (reset_shift),
    .keypad_buttons (keypad_buttons),
    .keypad_values  (keypad_values),
    .shift_pulse    (shift_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end else begin
      $display("ok   %s: %h", tag, obs);
    end
  endtask

  // Advance one clock and sample outputs 1 ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
    step_no++;
    if (shift_pulse === 1'b1) begin
      pulses++;
      if (first_at == 0) first_at = step_no;
    end
  endtask

  task automatic hold(input logic [9:0] b, input int n);
    keypad_buttons = b;
    step_no  = 0;
    first_at = 0;
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    logic [15:0] exp_seq [1:9];
    logic [9:0]  key;
    n_cmp = 0;
    n_err = 0;
    pulses = 0;
    step_no = 0;
    first_at = 0;
    exp_seq[1] = 16'h0001; exp_seq[2] = 16'h0012; exp_seq[3] = 16'h0123;
    exp_seq[4] = 16'h1234; exp_seq[5] = 16'h2345; exp_seq[6] = 16'h3456;
    exp_seq[7] = 16'h4567; exp_seq[8] = 16'h5678; exp_seq[9] = 16'h6789;

    // 1. reset
    reset_shift    = 1'b0;
    keypad_buttons = 10'h000;
    hold(10'h000, 2);
    check("reset_values", keypad_values, 16'h0000);
    check("reset_pulse", {15'd0, shift_pulse}, 16'h0000);
    reset_shift = 1'b1;
    hold(10'h000, 2);

    // 2. key 0: one pulse, 3 cycles after the first sampled edge
    pulses = 0;
    hold(10'h001, 6);
    check("key0_first_pulse_step", 16'(first_at), 16'd4);
    hold(10'h000, 6);
    check("key0_pulses", 16'(pulses), 16'd1);
    check("key0_value", keypad_values, 16'h0000);

    // 3/4. keys 1..9, oldest digits dropped
    for (int k = 1; k <= 9; k++) begin
      key = 10'h001 << k;
      pulses = 0;
      hold(key, 6);
      hold(10'h000, 6);
      check($sformatf("key%0d_value", k), keypad_values, exp_seq[k]);
      check($sformatf("key%0d_pulses", k), 16'(pulses), 16'd1);
    end

    // 5. multi-key ignored, single-cycle glitch rejected
    pulses = 0;
    hold(10'h003, 10);
    hold(10'h004, 1);
    hold(10'h000, 6);
    check("invalid_glitch_pulses", 16'(pulses), 16'd0);
    check("invalid_glitch_value", keypad_values, 16'h6789);

    // 6. key 7 held through a reset pulse
    pulses = 0;
    hold(10'h080, 6);
    check("key7_pre_reset_value", keypad_values, 16'h7897);
    reset_shift = 1'b0;
    hold(10'h080, 1);
    check("reset_mid_hold_value", keypad_values, 16'h0000);
    check("reset_mid_hold_pulse", {15'd0, shift_pulse}, 16'h0000);
    reset_shift = 1'b1;
    pulses = 0;
    hold(10'h080, 6);
    check("key7_after_reset_first_pulse", 16'(first_at), 16'd4);
    hold(10'h000, 6);
    check("key7_after_reset_pulses", 16'(pulses), 16'd1);
    check("key7_after_reset_value", keypad_values, 16'h0007);

    // 7. switch key 1 -> key 2 without release: only one shift
    pulses = 0;
    hold(10'h002, 6);
    hold(10'h004, 6);
    hold(10'h000, 6);
    check("switch_pulses", 16'(pulses), 16'd1);
    check("switch_value", keypad_values, 16'h0071);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
